// File: rtl/direction_scheduler.sv
// Debounced four-button direction input with a small queue of legal turns,
// releasing one queued direction per game tick.
module direction_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned QUEUE_DEPTH     = 2,
  parameter logic [1:0]  INIT_DIR        = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       dir_update,
  output logic [2:0] q_count,
  output logic       press_drop
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    Q_FULL   = 3'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    RELEASED,
    CONFIRM_PRESS,
    PRESSED,
    CONFIRM_RELEASE
  } db_state_t;

  // Bit index equals the direction code, so index order is also the priority order.
  logic [3:0] btn_raw;
  logic [3:0] sync_a, sync_b;
  logic [3:0] press_evt;

  db_state_t     db_state [4];
  db_state_t     db_next  [4];
  logic [CW-1:0] db_cnt   [4];
  logic [CW-1:0] cnt_next [4];

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        db_state[i] <= RELEASED;
        db_cnt[i]   <= '0;
      end
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      for (int unsigned i = 0; i < 4; i++) begin
        db_state[i] <= db_next[i];
        db_cnt[i]   <= cnt_next[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      db_next[i]   = db_state[i];
      cnt_next[i]  = db_cnt[i];
      press_evt[i] = 1'b0;
      case (db_state[i])
        RELEASED:
          if (sync_b[i]) begin
            db_next[i]  = CONFIRM_PRESS;
            cnt_next[i] = '0;
          end
        CONFIRM_PRESS:
          if (!sync_b[i]) begin
            db_next[i] = RELEASED;
          end else if (db_cnt[i] == CNT_LAST) begin
            db_next[i]   = PRESSED;
            press_evt[i] = 1'b1;
          end else begin
            cnt_next[i] = db_cnt[i] + 1'b1;
          end
        PRESSED:
          if (!sync_b[i]) begin
            db_next[i]  = CONFIRM_RELEASE;
            cnt_next[i] = '0;
          end
        CONFIRM_RELEASE:
          if (sync_b[i]) begin
            db_next[i] = PRESSED;
          end else if (db_cnt[i] == CNT_LAST) begin
            db_next[i] = RELEASED;
          end else begin
            cnt_next[i] = db_cnt[i] + 1'b1;
          end
        default: db_next[i] = RELEASED;
      endcase
    end
  end

  logic [1:0]    q_mem [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          win_valid, loser_any, pop, push, drop_next;
  logic [1:0]    win_dir, ref_dir;

  always_comb begin
    win_valid = 1'b0;
    win_dir   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (press_evt[i] && !win_valid) begin
        win_valid = 1'b1;
        win_dir   = 2'(i);
      end
    end
    loser_any = win_valid && ((press_evt & ~(4'b0001 << win_dir)) != '0);
    // Reference is taken before any pop on this edge.
    ref_dir   = (q_count != '0) ? q_mem[wr_ptr - 1'b1] : dir;
    pop       = tick && (q_count != '0);
    push      = win_valid && (win_dir != ref_dir) && (win_dir != (ref_dir ^ 2'b01))
                && ((q_count != Q_FULL) || pop);
    drop_next = (win_valid && !push) || loser_any;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir        <= INIT_DIR;
      dir_update <= 1'b0;
      press_drop <= 1'b0;
      q_count    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) q_mem[i] <= '0;
    end else begin
      dir_update <= pop;
      press_drop <= drop_next;
      if (push) begin
        q_mem[wr_ptr] <= win_dir;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        dir    <= q_mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

endmodule

// File: tb/tb_direction_scheduler.sv
// Directed and randomized checks of direction_scheduler against a queue-based
// model of the acceptance rules.
module tb_direction_scheduler;

  localparam int unsigned DB = 4;
  localparam int unsigned QD = 2;
  localparam logic [1:0]  INIT = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] dir;
  logic       dir_update;
  logic [2:0] q_count;
  logic       press_drop;

  direction_scheduler #(
    .DEBOUNCE_CYCLES(DB),
    .QUEUE_DEPTH(QD),
    .INIT_DIR(INIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .tick(tick),
    .dir(dir),
    .dir_update(dir_update),
    .q_count(q_count),
    .press_drop(press_drop)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0, checks = 0;
  int unsigned drop_seen = 0, upd_seen = 0, exp_drop = 0, exp_upd = 0;
  logic [1:0]  mq[$];
  logic [1:0]  mdir;

  always @(negedge clk) begin
    if (press_drop === 1'b1) drop_seen++;
    if (dir_update === 1'b1) upd_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_btns(input logic [3:0] m);
    {btn_right, btn_left, btn_down, btn_up} = m;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q_count"}, 32'(q_count), 32'(mq.size()));
    chk({tag, ".dir"}, 32'(dir), 32'(mdir));
    chk({tag, ".drops"}, drop_seen, exp_drop);
    chk({tag, ".updates"}, upd_seen, exp_upd);
  endtask

  // Reference: winner is the highest-priority button; filter against newest queued
  // entry (or dir); a pop on the same edge frees a slot but does not change the reference.
  task automatic model_press(input logic [3:0] mask, input bit pop_now);
    int         win = -1;
    int         n = 0;
    logic [1:0] c, r;
    bit         ok;
    for (int i = 0; i < 4; i++) if (mask[i]) begin n++; if (win < 0) win = i; end
    c  = 2'(win);
    r  = (mq.size() > 0) ? mq[mq.size()-1] : mdir;
    ok = (c != r) && (c != (r ^ 2'b01)) && ((mq.size() < QD) || (pop_now && mq.size() > 0));
    if (pop_now && mq.size() > 0) begin mdir = mq.pop_front(); exp_upd++; end
    if (ok) mq.push_back(c);
    if (!ok || n > 1) exp_drop++;
  endtask

  task automatic model_tick();
    if (mq.size() > 0) begin mdir = mq.pop_front(); exp_upd++; end
  endtask

  task automatic press_op(input logic [3:0] mask, input string tag);
    set_btns(mask);
    cyc(10);
    set_btns(4'b0000);
    cyc(10);
    model_press(mask, 1'b0);
    check_all(tag);
  endtask

  task automatic tick_op(input string tag);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(2);
    model_tick();
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    mq.delete();
    mdir = INIT;
    chk({tag, ".async_q_count"}, 32'(q_count), 32'd0);
    chk({tag, ".async_dir"}, 32'(dir), 32'(INIT));
    chk({tag, ".async_pulses"}, {30'd0, dir_update, press_drop}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(2);
    check_all({tag, ".released"});
  endtask

  initial begin
    logic [3:0] m;
    mdir = INIT;
    cyc(3);
    do_reset("reset");

    // Reversal and repeat of the current direction.
    press_op(4'b0100, "reversal_left");
    press_op(4'b1000, "repeat_right");

    // Bouncing up button: 2-cycle pulses never qualify, then a steady hold.
    for (int k = 0; k < 5; k++) begin
      btn_up = 1'b1; cyc(2);
      btn_up = 1'b0; cyc(2);
    end
    chk("bounce.no_push", 32'(q_count), 32'd0);
    press_op(4'b0001, "bounce_hold");
    tick_op("bounce_tick");

    // Double tap queues two turns; a third press while full is dropped.
    do_reset("reset2");
    press_op(4'b0001, "dtap_up");
    press_op(4'b0100, "dtap_left");
    press_op(4'b0010, "dtap_full_down");
    tick_op("dtap_tick1");
    tick_op("dtap_tick2");
    tick_op("tick_empty");

    // Asynchronous reset with a full queue.
    press_op(4'b0001, "mid_up");
    press_op(4'b0100, "mid_left");
    do_reset("reset_midq");

    // Two simultaneous events: up wins, left is dropped.
    press_op(4'b0101, "simul_up_left");
    press_op(4'b0100, "fill_left");

    // Tick lands on the edge where the debounced down event is pushed into a full queue.
    set_btns(4'b0010);
    cyc(2 + DB);
    chk("coinc.pre_full", 32'(q_count), 32'd2);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    set_btns(4'b0000);
    cyc(10);
    model_press(4'b0010, 1'b1);
    check_all("coinc_tick_push");
    tick_op("coinc_drain1");
    tick_op("coinc_drain2");

    // Randomized presses and ticks.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 6) begin
        if ($urandom_range(0, 3) == 0) m = 4'($urandom_range(1, 15));
        else m = 4'b0001 << $urandom_range(0, 3);
        press_op(m, $sformatf("rand%0d_press%0h", it, m));
      end else begin
        tick_op($sformatf("rand%0d_tick", it));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
